// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load-store unit: access sizes, bus FSM states,
// store-buffer entries, the Wishbone master bundle and the byte-lane helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    STORE = 2'b10
  } lsu_state_e;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
  } sb_entry_t;

  localparam int TAG_W = 4;

  typedef struct packed {
    logic             cyc;
    logic             stb;
    logic             we;
    logic [31:0]      adr;
    logic [31:0]      dat;
    logic [3:0]       sel;
    logic [TAG_W-1:0] tgd;
    logic [TAG_W-1:0] tga;
    logic [TAG_W-1:0] tgc;
    logic             lock;
  } wb_master_bus_t;

  // Size 11 has no legal encoding, so it is folded into the misaligned case.
  function automatic logic is_misaligned(input logic [1:0] off, input logic [1:0] size);
    logic bad;
    case (size)
      BYTE:    bad = 1'b0;
      HALF:    bad = off[0];
      WORD:    bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] gen_sel(input logic [1:0] off, input logic [1:0] size);
    logic [3:0] sel;
    case (size)
      BYTE:    sel = 4'b0001 << off;
      HALF:    sel = off[1] ? 4'b1100 : 4'b0011;
      WORD:    sel = 4'b1111;
      default: sel = 4'b0000;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] align_store(input logic [31:0] data, input logic [1:0] off);
    return data << {off, 3'b000};
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] size, input logic uns);
    logic [31:0] shifted;
    logic [31:0] result;
    shifted = word >> {off, 3'b000};
    case (size)
      BYTE:    result = uns ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      HALF:    result = uns ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: result = shifted;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/store_buffer.sv
// Circular FIFO of posted stores with a combinational word-address probe used to
// detect loads that would otherwise bypass an older store to the same word.
module store_buffer
  import lsu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn_i,
  input  logic        push,
  input  logic        pop,
  input  sb_entry_t   entry,
  input  logic [29:0] probe,
  output logic        full,
  output logic        empty,
  output sb_entry_t   head,
  output logic        hit_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t          mem [DEPTH];
  logic [DEPTH-1:0]   valid;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  // When full, push and pop share a slot; the head is read out before the edge overwrites it.
  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (pop) begin
        rd_ptr        <= rd_ptr + 1'b1;
        valid[rd_ptr] <= 1'b0;
      end
      if (push) begin
        wr_ptr        <= wr_ptr + 1'b1;
        valid[wr_ptr] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= entry;
    end
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_comb begin
    hit_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (mem[i].addr == probe)) begin
        hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lsu_sb.sv
// Load-store unit with a posted store buffer in front of one Wishbone master port.
// Stores retire on entry to the buffer; loads bypass it unless a word address matches.
module lsu_sb
  import lsu_pkg::*;
#(
  parameter int SB_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rstn_i,
  input  logic           read_i,
  input  logic           write_i,
  input  logic           fence_i,
  input  logic [31:0]    addr_i,
  input  logic [31:0]    data_i,
  input  logic [1:0]     size_i,
  input  logic           unsigned_i,
  output logic [31:0]    data_o,
  output logic           valid_o,
  output logic           misaligned_o,
  output logic           err_o,
  output logic           store_err_o,
  output wb_master_bus_t wb_bus,
  input  logic [31:0]    wb_dat_i,
  input  logic           wb_ack_i,
  input  logic           wb_err_i,
  input  logic           wb_rty_i
);

  lsu_state_e state;
  lsu_state_e next_state;
  lsu_state_e retry_q;

  logic       req_read;
  logic       req_write;
  logic       req_fence;
  logic       misaligned;
  logic       bad_req;
  logic [3:0] sel;
  logic       load_go;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  logic       hit;
  logic       load_done;
  sb_entry_t  new_entry;
  sb_entry_t  head;

  always_comb begin
    req_read   = read_i;
    req_write  = write_i & ~read_i;
    req_fence  = fence_i & ~read_i & ~write_i;
    misaligned = is_misaligned(addr_i[1:0], size_i);
    bad_req    = misaligned & (req_read | req_write);
    sel        = gen_sel(addr_i[1:0], size_i);
    load_go    = req_read & ~misaligned & ~hit;
  end

  // A full buffer still accepts a store in the cycle its head drains.
  assign pop       = (state == STORE) & (wb_ack_i | wb_err_i);
  assign push      = req_write & ~misaligned & (~full | pop);
  assign new_entry = '{addr: addr_i[31:2], data: align_store(data_i, addr_i[1:0]), sel: sel};

  store_buffer #(
    .DEPTH(SB_DEPTH)
  ) u_sb (
    .clk   (clk),
    .rstn_i(rstn_i),
    .push  (push),
    .pop   (pop),
    .entry (new_entry),
    .probe (addr_i[31:2]),
    .full  (full),
    .empty (empty),
    .head  (head),
    .hit_o (hit)
  );

  // retry_q remembers which access a rty interrupted so IDLE can reissue it unchanged.
  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      state   <= IDLE;
      retry_q <= IDLE;
    end else begin
      state <= next_state;
      if ((state != IDLE) && wb_rty_i && !wb_ack_i && !wb_err_i) begin
        retry_q <= state;
      end else if (state == IDLE) begin
        retry_q <= IDLE;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if ((retry_q == STORE) && !empty) begin
          next_state = STORE;
        end else if (load_go) begin
          next_state = LOAD;
        end else if (!empty) begin
          next_state = STORE;
        end
      end
      LOAD, STORE: begin
        if (wb_ack_i || wb_err_i || wb_rty_i) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    wb_bus       = '0;
    data_o       = '0;
    err_o        = 1'b0;
    store_err_o  = 1'b0;
    load_done    = 1'b0;
    case (state)
      LOAD: begin
        wb_bus.cyc = 1'b1;
        wb_bus.stb = 1'b1;
        wb_bus.adr = {addr_i[31:2], 2'b00};
        wb_bus.sel = sel;
        if (wb_err_i) begin
          load_done = 1'b1;
          err_o     = 1'b1;
        end else if (wb_ack_i) begin
          load_done = 1'b1;
          data_o    = extract_load(wb_dat_i, addr_i[1:0], size_i, unsigned_i);
        end
      end
      STORE: begin
        wb_bus.cyc  = 1'b1;
        wb_bus.stb  = 1'b1;
        wb_bus.we   = 1'b1;
        wb_bus.adr  = {head.addr, 2'b00};
        wb_bus.dat  = head.data;
        wb_bus.sel  = head.sel;
        store_err_o = wb_err_i;
      end
      default: ;
    endcase
    misaligned_o = bad_req;
    valid_o      = bad_req | push | load_done | (req_fence & empty & (state == IDLE));
  end

endmodule

// File: tb/tb_lsu_sb.sv
// Directed self-checking bench for lsu_sb: the Wishbone slave is driven by hand
// and every expected value below is worked out from the byte-lane rules.
module tb_lsu_sb;
  import lsu_pkg::*;

  logic           clk = 1'b0;
  logic           rstn_i;
  logic           read_i, write_i, fence_i, unsigned_i;
  logic [31:0]    addr_i, data_i;
  logic [1:0]     size_i;
  logic [31:0]    data_o;
  logic           valid_o, misaligned_o, err_o, store_err_o;
  wb_master_bus_t wb_bus;
  logic [31:0]    wb_dat_i;
  logic           wb_ack_i, wb_err_i, wb_rty_i;

  int total = 0;
  int bad = 0;
  int last_wait = 0;
  bit ok;
  logic [31:0] fill_dat [5];

  always #5 clk = ~clk;

  lsu_sb #(
    .SB_DEPTH(4)
  ) dut (
    .clk         (clk),
    .rstn_i      (rstn_i),
    .read_i      (read_i),
    .write_i     (write_i),
    .fence_i     (fence_i),
    .addr_i      (addr_i),
    .data_i      (data_i),
    .size_i      (size_i),
    .unsigned_i  (unsigned_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .misaligned_o(misaligned_o),
    .err_o       (err_o),
    .store_err_o (store_err_o),
    .wb_bus      (wb_bus),
    .wb_dat_i    (wb_dat_i),
    .wb_ack_i    (wb_ack_i),
    .wb_err_i    (wb_err_i),
    .wb_rty_i    (wb_rty_i)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic fn, input logic [31:0] addr,
                               input logic [31:0] data, input logic [1:0] size, input logic uns);
    read_i     = rd;
    write_i    = wr;
    fence_i    = fn;
    addr_i     = addr;
    data_i     = data;
    size_i     = size;
    unsigned_i = uns;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
  endtask

  // Polls for a bus cycle of the wanted direction, giving up after a fixed budget.
  task automatic waitBus(input logic we_exp, input string tag, output bit found);
    found = 1'b0;
    last_wait = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (wb_bus.cyc === 1'b1 && wb_bus.we === we_exp) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
      last_wait++;
    end
    if (!found) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic drainEntry(input string tag, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    bit f;
    waitBus(1'b1, tag, f);
    if (f) begin
      checkOutput({tag, "_adr"}, wb_bus.adr, adr);
      checkOutput({tag, "_dat"}, wb_bus.dat, dat);
      checkOutput({tag, "_sel"}, {28'b0, wb_bus.sel}, {28'b0, sel});
      wb_ack_i = 1'b1;
      #1;
      checkOutput({tag, "_serr"}, {31'b0, store_err_o}, 32'd0);
      @(negedge clk);
      wb_ack_i = 1'b0;
    end
  endtask

  task automatic doLoad(input string tag, input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] slave,
                        input logic use_err, input logic [31:0] exp_data);
    bit f;
    waitBus(1'b0, tag, f);
    if (f) begin
      checkOutput({tag, "_adr"}, wb_bus.adr, adr);
      checkOutput({tag, "_sel"}, {28'b0, wb_bus.sel}, {28'b0, sel});
      wb_dat_i = slave;
      if (use_err) wb_err_i = 1'b1;
      else wb_ack_i = 1'b1;
      #1;
      checkOutput({tag, "_valid"}, {31'b0, valid_o}, 32'd1);
      checkOutput({tag, "_err"}, {31'b0, err_o}, {31'b0, use_err});
      checkOutput({tag, "_data"}, data_o, exp_data);
      @(negedge clk);
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      idleInputs();
      #1;
      checkOutput({tag, "_pulse"}, {31'b0, valid_o}, 32'd0);
    end
  endtask

  initial begin
    fill_dat = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
    rstn_i   = 1'b0;
    wb_dat_i = '0;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_rty_i = 1'b0;
    idleInputs();
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_cyc", {31'b0, wb_bus.cyc}, 32'd0);
    checkOutput("rst_stb_we", {30'b0, wb_bus.stb, wb_bus.we}, 32'd0);
    checkOutput("rst_adr", wb_bus.adr, 32'd0);
    checkOutput("rst_valid", {31'b0, valid_o}, 32'd0);
    checkOutput("rst_data", data_o, 32'd0);
    rstn_i = 1'b1;

    // Byte store, then a load to the same word must wait for the drain.
    @(negedge clk);
    applyStimulus(1'b1 ^ 1'b1, 1'b1, 1'b0, 32'h1003, 32'h000000AB, BYTE, 1'b0);
    #1;
    checkOutput("sb_valid", {31'b0, valid_o}, 32'd1);
    checkOutput("sb_misal", {31'b0, misaligned_o}, 32'd0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h1000, 32'h0, WORD, 1'b0);
    #1;
    checkOutput("lw_hazard_wait", {31'b0, valid_o}, 32'd0);
    drainEntry("sb_drain", 32'h1000, 32'hAB000000, 4'b1000);
    doLoad("lw_after", 32'h1000, 4'b1111, 32'hAB223344, 1'b0, 32'hAB223344);

    // Fill the buffer while the slave withholds ack; the fifth store stalls.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h100 + 32'(4 * k), fill_dat[k], WORD, 1'b0);
      #1;
      checkOutput($sformatf("fill%0d_valid", k), {31'b0, valid_o}, 32'd1);
    end
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h110, fill_dat[4], WORD, 1'b0);
    #1;
    checkOutput("fill4_stall", {31'b0, valid_o}, 32'd0);
    @(negedge clk);
    #1;
    checkOutput("fill4_stall2", {31'b0, valid_o}, 32'd0);
    checkOutput("fill_head_dat", wb_bus.dat, fill_dat[0]);
    wb_ack_i = 1'b1;
    #1;
    checkOutput("fill4_on_ack", {31'b0, valid_o}, 32'd1);
    @(negedge clk);
    wb_ack_i = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, WORD, 1'b0);
    #1;
    checkOutput("fence_wait", {31'b0, valid_o}, 32'd0);
    for (int k = 1; k < 5; k++) begin
      drainEntry($sformatf("fill_drain%0d", k), 32'h100 + 32'(4 * k), fill_dat[k], 4'b1111);
    end
    #1;
    checkOutput("fence_done", {31'b0, valid_o}, 32'd1);
    @(negedge clk);
    idleInputs();

    // Half-word load hazarding a word store, then bypass loads with extension.
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h2000, 32'h12345678, WORD, 1'b0);
    #1;
    checkOutput("sw_valid", {31'b0, valid_o}, 32'd1);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h2002, 32'h0, HALF, 1'b0);
    drainEntry("hz_drain", 32'h2000, 32'h12345678, 4'b1111);
    doLoad("lh", 32'h2000, 4'b1100, 32'h8765ABCD, 1'b0, 32'hFFFF8765);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h2002, 32'h0, HALF, 1'b1);
    #1;
    checkOutput("lhu_idle_cyc", {31'b0, wb_bus.cyc}, 32'd0);
    doLoad("lhu", 32'h2000, 4'b1100, 32'h8765ABCD, 1'b0, 32'h00008765);
    checkOutput("lhu_latency", 32'(last_wait), 32'd1);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h2001, 32'h0, BYTE, 1'b0);
    doLoad("lb", 32'h2000, 4'b0010, 32'h1234F600, 1'b0, 32'hFFFFFFF6);

    // Misaligned accesses complete at once and never reach the bus.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h3001, 32'h0, WORD, 1'b0);
    #1;
    checkOutput("ms_lw_valid", {31'b0, valid_o}, 32'd1);
    checkOutput("ms_lw_flag", {31'b0, misaligned_o}, 32'd1);
    checkOutput("ms_lw_data", data_o, 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h3001, 32'h1, HALF, 1'b0);
    #1;
    checkOutput("ms_lw_nocyc", {31'b0, wb_bus.cyc}, 32'd0);
    checkOutput("ms_sh_flag", {30'b0, valid_o, misaligned_o}, 32'd3);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h3000, 32'h0, 2'b11, 1'b0);
    #1;
    checkOutput("ms_size11_flag", {30'b0, valid_o, misaligned_o}, 32'd3);
    @(negedge clk);
    idleInputs();
    repeat (2) begin
      @(negedge clk);
      #1;
      checkOutput("ms_nodrain", {31'b0, wb_bus.cyc}, 32'd0);
    end

    // Load error, store retry and store error.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h4000, 32'h0, WORD, 1'b0);
    doLoad("lw_err", 32'h4000, 4'b1111, 32'hDEADBEEF, 1'b1, 32'h0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h5000, 32'hCAFEF00D, WORD, 1'b0);
    #1;
    checkOutput("rty_sw_valid", {31'b0, valid_o}, 32'd1);
    @(negedge clk);
    idleInputs();
    waitBus(1'b1, "rty", ok);
    if (ok) begin
      wb_rty_i = 1'b1;
      #1;
      checkOutput("rty_no_serr", {31'b0, store_err_o}, 32'd0);
      @(negedge clk);
      wb_rty_i = 1'b0;
      #1;
      checkOutput("rty_idle", {31'b0, wb_bus.cyc}, 32'd0);
      @(negedge clk);
      #1;
      checkOutput("rty_reissue", {31'b0, wb_bus.cyc}, 32'd1);
      checkOutput("rty_dat", wb_bus.dat, 32'hCAFEF00D);
      wb_ack_i = 1'b1;
      @(negedge clk);
      wb_ack_i = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, WORD, 1'b0);
      #1;
      checkOutput("rty_single_pop", {31'b0, valid_o}, 32'd1);
      @(negedge clk);
      idleInputs();
      #1;
      checkOutput("rty_quiet", {31'b0, wb_bus.cyc}, 32'd0);
    end
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h6001, 32'h0000005A, BYTE, 1'b0);
    @(negedge clk);
    idleInputs();
    waitBus(1'b1, "serr", ok);
    if (ok) begin
      checkOutput("serr_sel", {28'b0, wb_bus.sel}, 32'h2);
      checkOutput("serr_dat", wb_bus.dat, 32'h00005A00);
      wb_err_i = 1'b1;
      #1;
      checkOutput("serr_pulse", {31'b0, store_err_o}, 32'd1);
      @(negedge clk);
      wb_err_i = 1'b0;
      #1;
      checkOutput("serr_clear", {31'b0, store_err_o}, 32'd0);
    end

    // Reset while a load is on the bus, with a store still buffered.
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h7100, 32'h77, WORD, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h7000, 32'h0, WORD, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("load_wins", {30'b0, wb_bus.cyc, wb_bus.we}, 32'd2);
    rstn_i = 1'b0;
    idleInputs();
    @(negedge clk);
    rstn_i = 1'b1;
    #1;
    checkOutput("rst_mid_cyc", {30'b0, wb_bus.cyc, wb_bus.stb}, 32'd0);
    checkOutput("rst_mid_valid", {31'b0, valid_o}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, WORD, 1'b0);
    #1;
    checkOutput("rst_sb_empty", {31'b0, valid_o}, 32'd1);
    @(negedge clk);
    idleInputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
